// File: rtl/m_s_to_p_pkg.sv
// m_s_to_p_pkg: shared types and sizing helper for the m_s_to_p_frame deserializer
package m_s_to_p_pkg;
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  // Bit counter width. A range of 0..WORD (parity build) still fits in $clog2(WORD+1).
  function automatic int cnt_w(input int word);
    return $clog2(word + 1);
  endfunction
endpackage

// File: rtl/m_sp_shift.sv
// m_sp_shift: direction-parametrised shift register with clear, enable and next-value output
// Ports: clk_i, rst_i (async, active-high), clr_i (sync clear, wins over en_i),
//        en_i (shift d_i in), d_i (serial bit), q_o (current value), nxt_o (value after one shift)
module m_sp_shift #(
  parameter int WORD      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            d_i,
  output logic [WORD-1:0] q_o,
  output logic [WORD-1:0] nxt_o
);
  logic [WORD-1:0] sr_q;
  always_comb nxt_o = MSB_FIRST ? {sr_q[WORD-2:0], d_i} : {d_i, sr_q[WORD-1:1]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sr_q <= '0;
    else if (clr_i) sr_q <= '0;
    else if (en_i) sr_q <= nxt_o;
  assign q_o = sr_q;
endmodule

// File: rtl/m_s_to_p_frame.sv
// m_s_to_p_frame: framed serial-to-parallel deserializer with registered valid/ready output
// Ports: clk_i, reset_i (async, active-high), start_i (frame start pulse), bit_valid_i,
//        serial_d_i, out_ready_i, clr_ovr_i, parallel_out_o, out_valid_o, busy_o, overrun_o,
//        parity_err_o (only with M_S_TO_P_PARITY_EN: a trailing even-parity bit ends each frame)
module m_s_to_p_frame
  import m_s_to_p_pkg::*;
#(
  parameter int WORD      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            bit_valid_i,
  input  logic            serial_d_i,
  input  logic            out_ready_i,
  input  logic            clr_ovr_i,
  output logic [WORD-1:0] parallel_out_o,
  output logic            out_valid_o,
  output logic            busy_o,
  output logic            overrun_o
`ifdef M_S_TO_P_PARITY_EN
  ,
  output logic            parity_err_o
`endif
);
  localparam int CW = cnt_w(WORD);
`ifdef M_S_TO_P_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WORD);
`else
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);
`endif
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WORD-1:0] sr_q, sr_nxt, po_q, po_d;
  logic            valid_q, ovr_q, take, done, sh_en, perr_q, perr_d;
  // A completing bit is honoured even when start_i arrives with it; otherwise start_i discards the bit.
  always_comb begin
    take = state_q == S_SHIFT && bit_valid_i;
    done = take && cnt_q == LAST;
`ifdef M_S_TO_P_PARITY_EN
    sh_en  = take && !start_i && !done;
    po_d   = sr_q;
    perr_d = ^{sr_q, serial_d_i};
`else
    sh_en  = take && !start_i;
    po_d   = sr_nxt;
    perr_d = 1'b0;
`endif
  end
  m_sp_shift #(.WORD(WORD), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (start_i),
    .en_i  (sh_en),
    .d_i   (serial_d_i),
    .q_o   (sr_q),
    .nxt_o (sr_nxt)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (start_i) begin
        state_q <= S_SHIFT;
        cnt_q   <= '0;
      end else if (done) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else if (take) cnt_q <= cnt_q + 1'b1;
      // A completion may load only if the held word is gone or leaves on this same edge.
      if (done && (!valid_q || out_ready_i)) begin
        po_q    <= po_d;
        perr_q  <= perr_d;
        valid_q <= 1'b1;
      end else if (valid_q && out_ready_i) valid_q <= 1'b0;
      ovr_q <= (done && valid_q && !out_ready_i) || (ovr_q && !clr_ovr_i);
    end
  assign parallel_out_o = po_q;
  assign out_valid_o    = valid_q;
  assign busy_o         = state_q == S_SHIFT;
  assign overrun_o      = ovr_q;
`ifdef M_S_TO_P_PARITY_EN
  assign parity_err_o   = perr_q;
`else
  logic unused_perr;
  assign unused_perr    = perr_q;
`endif
endmodule

// File: tb/tb_m_s_to_p_frame.sv
// tb_m_s_to_p_frame: directed bench for m_s_to_p_frame, MSB-first and LSB-first instances side by side
module tb_m_s_to_p_frame;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, bv = 1'b0, sd = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [7:0] po_m, po_l;
  logic       val_m, val_l, busy_m, busy_l, ovr_m, ovr_l;
  int         total = 0, bad = 0;
`ifdef M_S_TO_P_PARITY_EN
  logic       pe_m, pe_l;
`endif
  always #5 clk = ~clk;
  m_s_to_p_frame #(.WORD(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .reset_i(rst), .start_i(start), .bit_valid_i(bv), .serial_d_i(sd),
    .out_ready_i(rdy), .clr_ovr_i(clr), .parallel_out_o(po_m), .out_valid_o(val_m),
    .busy_o(busy_m), .overrun_o(ovr_m)
`ifdef M_S_TO_P_PARITY_EN
    , .parity_err_o(pe_m)
`endif
  );
  m_s_to_p_frame #(.WORD(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .reset_i(rst), .start_i(start), .bit_valid_i(bv), .serial_d_i(sd),
    .out_ready_i(rdy), .clr_ovr_i(clr), .parallel_out_o(po_l), .out_valid_o(val_l),
    .busy_o(busy_l), .overrun_o(ovr_l)
`ifdef M_S_TO_P_PARITY_EN
    , .parity_err_o(pe_l)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input bit gap);
    if (gap) begin
      bv = 1'b0;
      tick();
    end
    bv = 1'b1;
    sd = b;
    tick();
  endtask
  // all data bits except the one that completes the frame
  task automatic pre(input logic [7:0] b, input bit gap);
    for (int i = 7; i >= 1; i--) send(b[i], gap);
`ifdef M_S_TO_P_PARITY_EN
    send(b[0], gap);
`endif
  endtask
  // the completing bit: last data bit, or the even-parity bit (optionally corrupted)
  task automatic lastbit(input logic [7:0] b, input bit gap, input bit flip);
`ifdef M_S_TO_P_PARITY_EN
    send((^b) ^ flip, gap);
`else
    send(b[0] ^ flip, gap);
`endif
    bv = 1'b0;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    bv = 1'b1;
    sd = 1'b0;
    tick();
    start = 1'b0;
  endtask
  task automatic frame(input logic [7:0] b, input bit gap);
    pulse_start();
    pre(b, gap);
    lastbit(b, gap, 1'b0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_po_m", po_m, 8'h00);
    chk("rst_po_l", po_l, 8'h00);
    chk("rst_val", {val_m, val_l}, 2'b00);
    chk("rst_busy", {busy_m, busy_l}, 2'b00);
    chk("rst_ovr", {ovr_m, ovr_l}, 2'b00);
    rst = 1'b0;
    rdy = 1'b1;
    frame(8'hA5, 1'b0);
    chk("a5_po_m", po_m, 8'hA5);
    chk("a5_po_l", po_l, 8'hA5);
    chk("a5_val", {val_m, val_l}, 2'b11);
    chk("a5_busy", {busy_m, busy_l}, 2'b00);
    tick();
    chk("a5_val_drop", {val_m, val_l}, 2'b00);
    frame(8'hC0, 1'b0);
    chk("c0_po_m", po_m, 8'hC0);
    chk("c0_po_l", po_l, 8'h03);
    tick();
    rdy = 1'b0;
    frame(8'h3C, 1'b0);
    chk("3c_po_m", po_m, 8'h3C);
    chk("3c_val", {val_m, val_l}, 2'b11);
    frame(8'h5A, 1'b0);
    chk("ovr_po_m", po_m, 8'h3C);
    chk("ovr_po_l", po_l, 8'h3C);
    chk("ovr_set", {ovr_m, ovr_l}, 2'b11);
    chk("ovr_val", {val_m, val_l}, 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clr", {ovr_m, ovr_l}, 2'b00);
    chk("ovr_val_hold", {val_m, val_l}, 2'b11);
    rdy = 1'b1;
    tick();
    chk("ovr_consumed", {val_m, val_l}, 2'b00);
    frame(8'h96, 1'b1);
    chk("gap_po_m", po_m, 8'h96);
    chk("gap_po_l", po_l, 8'h69);
    tick();
    pulse_start();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    frame(8'hFF, 1'b0);
    chk("restart_po_m", po_m, 8'hFF);
    chk("restart_po_l", po_l, 8'hFF);
    chk("restart_val", {val_m, val_l}, 2'b11);
    tick();
    rdy = 1'b0;
    frame(8'h11, 1'b0);
    pulse_start();
    pre(8'hE6, 1'b0);
    rdy = 1'b1;
    lastbit(8'hE6, 1'b0, 1'b0);
    chk("swap_val", {val_m, val_l}, 2'b11);
    chk("swap_po_m", po_m, 8'hE6);
    chk("swap_po_l", po_l, 8'h67);
    chk("swap_ovr", {ovr_m, ovr_l}, 2'b00);
    tick();
    chk("swap_consumed", {val_m, val_l}, 2'b00);
    pulse_start();
    pre(8'h28, 1'b0);
    start = 1'b1;
    lastbit(8'h28, 1'b0, 1'b0);
    start = 1'b0;
    chk("sol_po_m", po_m, 8'h28);
    chk("sol_po_l", po_l, 8'h14);
    chk("sol_busy", {busy_m, busy_l}, 2'b11);
    pre(8'h4D, 1'b0);
    lastbit(8'h4D, 1'b0, 1'b0);
    chk("sol_next_po_m", po_m, 8'h4D);
    chk("sol_next_po_l", po_l, 8'hB2);
    tick();
    rdy = 1'b0;
    frame(8'hA5, 1'b0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bv = 1'b1;
      sd = 1'b1;
      tick();
    end
    rst = 1'b1;
    #2;
    chk("arst_po", {po_m, po_l}, 16'h0000);
    chk("arst_val", {val_m, val_l}, 2'b00);
    chk("arst_busy", {busy_m, busy_l}, 2'b00);
    rst = 1'b0;
    bv = 1'b0;
    tick();
    rdy = 1'b1;
    frame(8'h81, 1'b0);
    chk("post_rst_po_m", po_m, 8'h81);
    chk("post_rst_po_l", po_l, 8'h81);
    chk("post_rst_val", {val_m, val_l}, 2'b11);
    tick();
`ifdef M_S_TO_P_PARITY_EN
    frame(8'h07, 1'b0);
    chk("par_ok_po_m", po_m, 8'h07);
    chk("par_ok_po_l", po_l, 8'hE0);
    chk("par_ok_err", {pe_m, pe_l}, 2'b00);
    tick();
    pulse_start();
    pre(8'h07, 1'b0);
    lastbit(8'h07, 1'b0, 1'b1);
    chk("par_bad_po_m", po_m, 8'h07);
    chk("par_bad_err", {pe_m, pe_l}, 2'b11);
    tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
